// File: rtl/fixed_encoder_if.sv
// Sample-in / residual-out bus of the fixed-predictor encoder.
// The master drives the samples and controls; the slave returns the residuals.
interface fixed_encoder_if #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int RESIDUAL_WIDTH = SAMPLE_WIDTH + 4
);
  logic                             iStart;
  logic [2:0]                       iOrder;
  logic                             iEnable;
  logic signed [SAMPLE_WIDTH-1:0]   iSample;
  logic signed [RESIDUAL_WIDTH-1:0] oData;
  logic                             oValid;
  logic                             oWarmup;

  modport master (
    output iStart, iOrder, iEnable, iSample,
    input  oData, oValid, oWarmup
  );

  modport slave (
    input  iStart, iOrder, iEnable, iSample,
    output oData, oValid, oWarmup
  );
endinterface

// File: rtl/fixed_encoder.sv
// FLAC fixed-predictor encoder, orders 0-4: emits verbatim warm-up samples,
// then fixed-order residuals, one sample per clock with a registered output.
module fixed_encoder #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int RESIDUAL_WIDTH = SAMPLE_WIDTH + 4
) (
  input  logic           iClock,
  input  logic           iReset_n,
  fixed_encoder_if.slave bus
);
  localparam int EXT = RESIDUAL_WIDTH - SAMPLE_WIDTH;

  typedef logic signed [SAMPLE_WIDTH-1:0]   smp_t;
  typedef logic signed [RESIDUAL_WIDTH-1:0] res_t;

  logic [2:0] order;
  logic [2:0] cnt;
  smp_t       x1, x2, x3, x4;

  logic [2:0] newOrder, effOrder, effCnt;
  smp_t       h1, h2, h3, h4;
  res_t       e0, e1, e2, e3, e4;
  res_t       residual;
  logic       isWarmup;

  function automatic res_t sext(input smp_t s);
    return {{EXT{s[SAMPLE_WIDTH-1]}}, s};
  endfunction

  // A start in the same cycle as a sample makes that sample the first of the
  // new subframe, so order, count and history are bypassed combinationally.
  always_comb begin
    newOrder = (bus.iOrder > 3'd4) ? 3'd4 : bus.iOrder;
    effOrder = bus.iStart ? newOrder : order;
    effCnt   = bus.iStart ? 3'd0 : cnt;
    h1       = bus.iStart ? '0 : x1;
    h2       = bus.iStart ? '0 : x2;
    h3       = bus.iStart ? '0 : x3;
    h4       = bus.iStart ? '0 : x4;
    e0       = sext(bus.iSample);
    e1       = sext(h1);
    e2       = sext(h2);
    e3       = sext(h3);
    e4       = sext(h4);
    isWarmup = (effCnt < effOrder);
    case (effOrder)
      3'd0:    residual = e0;
      3'd1:    residual = e0 - e1;
      3'd2:    residual = e0 - (e1 <<< 1) + e2;
      3'd3:    residual = e0 - ((e1 <<< 1) + e1) + ((e2 <<< 1) + e2) - e3;
      default: residual = e0 - (e1 <<< 2) + ((e2 <<< 2) + (e2 <<< 1))
                          - (e3 <<< 2) + e4;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      order       <= '0;
      cnt         <= '0;
      x1          <= '0;
      x2          <= '0;
      x3          <= '0;
      x4          <= '0;
      bus.oData   <= '0;
      bus.oValid  <= 1'b0;
      bus.oWarmup <= 1'b0;
    end else begin
      if (bus.iStart) begin
        order <= newOrder;
        cnt   <= '0;
        x1    <= '0;
        x2    <= '0;
        x3    <= '0;
        x4    <= '0;
      end
      if (bus.iEnable) begin
        x1          <= bus.iSample;
        x2          <= h1;
        x3          <= h2;
        x4          <= h3;
        // cnt stops at the order, so it never needs an explicit saturate.
        if (isWarmup) cnt <= effCnt + 3'd1;
        bus.oData   <= isWarmup ? e0 : residual;
        bus.oWarmup <= isWarmup;
        bus.oValid  <= 1'b1;
      end else begin
        bus.oValid  <= 1'b0;
        bus.oWarmup <= 1'b0;
      end
    end
  end
endmodule

// File: doc/fixed_encoder.md
# fixed_encoder

FLAC fixed-predictor encoder: converts a stream of signed PCM samples into the verbatim warm-up samples and fixed-order residuals for one subframe, for predictor orders 0–4. It sits in the encode path ahead of the Rice/residual coder. It is the exact inverse of the existing FixedDecoder: feeding this block's output, with the same order, into FixedDecoder reproduces the original samples. Processing is one sample per clock with a registered output.

## Interface
- SAMPLE_WIDTH, 16, width of signed input samples.
- RESIDUAL_WIDTH, SAMPLE_WIDTH+4, width of signed output; holds any order-4 residual without overflow.

- iClock  in  1  rising-edge clock.
- iReset_n  in  1  reset, asynchronous, active-low.
- iStart  in  1  start of a subframe; clears history and latches iOrder.
- iOrder  in  3  predictor order; 0–4 are valid, 5–7 are treated as 4; sampled only when iStart=1.
- iEnable  in  1  iSample is valid this cycle.
- iSample  in  SAMPLE_WIDTH  signed input sample.
- oData  out  RESIDUAL_WIDTH  signed warm-up sample (sign-extended) or residual.
- oValid  out  1  oData is valid.
- oWarmup  out  1  oData is a verbatim warm-up sample.

## Operation
- State:
  - order register (3 b);
  - history x1..x4 (SAMPLE_WIDTH each, x1 = most recent);
  - warm-up counter cnt (0..4, saturating).
- Reset (iReset_n=0, async): order=0, cnt=0, history=0, oData=0, oValid=0, oWarmup=0.
- iStart=1 at an edge:
  - order←min(iOrder,4);
  - cnt←0;
  - history←0.
  - If iEnable=1 in the same cycle, that sample is processed as the first sample of the new subframe (cnt treated as 0, iOrder used as the order).
- Accepted sample (iEnable=1), x0=iSample:
  - if cnt<order: oData←sext(x0), oWarmup←1, cnt←cnt+1;
  - else oWarmup←0 and oData is:
    - order 0: x0;
    - order 1: x0−x1;
    - order 2: x0−2x1+x2;
    - order 3: x0−3x1+3x2−x3;
    - order 4: x0−4x1+6x2−4x3+x4.
  - history shifts: x4←x3, x3←x2, x2←x1, x1←x0.
  - oValid←1.
- iEnable=0: history, cnt, and oData hold; oValid←0; oWarmup←0.
- Arithmetic:
  - all operands are sign-extended to RESIDUAL_WIDTH before add/sub;
  - multiples are built with shifts and adds (2x=x<<1, 3x=2x+x, 4x=x<<2, 6x=4x+2x);
  - no saturation, and none is needed.
- cnt saturates at order. Subframes of any length ≥ 0 are legal; subframes shorter than order emit only warm-up samples.

## Timing
- Latency is 1 cycle: a sample accepted at edge N appears on oData, oValid, and oWarmup immediately after edge N. Output changes only at edges, apart from async reset.
- Sustained throughput is 1 sample per cycle. There is no backpressure; the downstream block must accept every oValid cycle.
- Back-to-back subframes: asserting iStart with iEnable on the cycle after a subframe's last sample produces no gap in oValid.
- Reset asserted mid-subframe clears everything immediately. After release, iStart must be given before a new subframe; without it, order=0 applies.
- Changing iOrder without iStart has no effect.

## Test plan
- Order 0: iStart with iOrder=0, then samples 10, −7, −4, 8 → oData 10, −7, −4, 8; oWarmup=0 throughout; oValid high for 4 consecutive cycles.
- Order 1 and order 2, same samples:
  - order 1 → 10(w), −17, 3, 12;
  - order 2 → 10(w), −7(w), 20, 9.
  - Flag (w) = oWarmup=1.
- Order 3 and order 4:
  - order 3, samples 10, −7, −4, 8 → 10(w), −7(w), −4(w), −11;
  - order 4, samples 10, −7, −4, 8, 2 → four warm-up samples, then −16.
- Enable gaps and edge widths:
  - order 2, samples 10, −7, [iEnable=0 for 3 cycles], −4, 8 → same values as the gap-free run, oValid low during the gap.
  - Full-scale alternating samples +32767 / −32768 at order 4 → residuals exact, with no wrap.
- Control corner cases:
  - iOrder=6 → behaves exactly as order 4.
  - iStart+iEnable on the last cycle of a subframe → new subframe begins with warm-up, with no bubble.
  - iReset_n low mid-subframe → all outputs 0 immediately; the next subframe matches a fresh run.
- Round trip: random 1000-sample subframes at each order 0–4, fed into FixedDecoder with the same order → decoder output equals the original samples.
